// File: rtl/srl_udl_tracker.sv
// srl_udl_tracker: DEPTH-cycle shift-register delay line plus an up/down counter of pulses in flight.
// Optional build macro SRL_RESET_EN: RST_N also asynchronously clears the delay line.
module srl_udl_tracker #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int TMR   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             I,
  output logic             O,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             OVR
);

  // Power-up value only; without SRL_RESET_EN the stages map onto SRL primitives.
  logic [DEPTH-1:0] r_sr = '0;
  logic             w_o;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qNext;

`ifdef SRL_RESET_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sr <= '0;
    end else if (CE) begin
      r_sr[0] <= I;
      for (int k = 1; k < DEPTH; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (CE) begin
      r_sr[0] <= I;
      for (int k = 1; k < DEPTH; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end
`endif

  assign w_o = r_sr[DEPTH-1];

  // Entering and leaving pulses cancel; load wins over everything but reset.
  always_comb begin
    w_qNext = w_q;
    if (L) begin
      w_qNext = D;
    end else if (CE && (I ^ w_o)) begin
      w_qNext = I ? (w_q + WIDTH'(1)) : (w_q - WIDTH'(1));
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [WIDTH-1:0] r_qA;
      logic [WIDTH-1:0] r_qB;
      logic [WIDTH-1:0] r_qC;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_qA <= '0;
          r_qB <= '0;
          r_qC <= '0;
        end else begin
          r_qA <= w_qNext;
          r_qB <= w_qNext;
          r_qC <= w_qNext;
        end
      end

      assign w_q = (r_qA & r_qB) | (r_qA & r_qC) | (r_qB & r_qC);
    end else begin : g_single
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_q <= '0;
        end else begin
          r_q <= w_qNext;
        end
      end

      assign w_q = r_q;
    end
  endgenerate

  assign O   = w_o;
  assign Q   = w_q;
  assign OVR = w_q[WIDTH-1];

endmodule

// File: tb/tb_srl_udl_tracker.sv
// tb_srl_udl_tracker: directed checks of the delay line and in-flight counter (DEPTH=16, WIDTH=2).
// Reset-case expectations follow the SRL_RESET_EN build macro.
module tb_srl_udl_tracker;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CE;
  logic       I;
  logic       L;
  logic [1:0] D;
  logic       O;
  logic [1:0] Q;
  logic       OVR;

  int checks = 0;
  int errors = 0;

  srl_udl_tracker #(.DEPTH(16), .WIDTH(2), .TMR(0)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CE   (CE),
    .I    (I),
    .O    (O),
    .L    (L),
    .D    (D),
    .Q    (Q),
    .OVR  (OVR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic expO, input int expQ);
    logic [1:0] q2;
    q2 = 2'(expQ);
    checkValue({tag, " O"}, 32'(O), 32'(expO));
    checkValue({tag, " Q"}, 32'(Q), 32'(q2));
    checkValue({tag, " OVR"}, 32'(OVR), 32'(q2[1]));
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; I = 1'b0; L = 1'b0; D = 2'd0;
    #3;
    checkAll("reset", 1'b0, 0);
    #14;
    RST_N = 1'b1;
    tick();

    // single pulse: O one cycle, 16 edges after sampling
    I = 1'b1; tick(); I = 1'b0;
    checkAll("single e0", 1'b0, 1);
    for (int n = 1; n <= 16; n++) begin
      tick();
      checkAll($sformatf("single e%0d", n), n == 15, (n <= 15) ? 1 : 0);
    end

    // three overlapping pulses two cycles apart
    I = 1'b1; tick(); I = 1'b0; tick();
    I = 1'b1; tick(); I = 1'b0; tick();
    I = 1'b1; tick(); I = 1'b0;
    checkAll("triple e4", 1'b0, 3);
    for (int n = 5; n <= 22; n++) begin
      tick();
      checkAll($sformatf("triple e%0d", n), (n == 15) || (n == 17) || (n == 19),
               (n < 16) ? 3 : (n < 18) ? 2 : (n < 20) ? 1 : 0);
    end

    // I held high for 20 cycles: wrap, cancel, then wrapping decrements
    for (int n = 0; n <= 36; n++) begin
      int expQ;
      I = (n < 20);
      tick();
      if (n <= 15)      expQ = (n + 1) % 4;
      else if (n <= 19) expQ = 0;
      else if (n <= 35) expQ = (4 - ((n - 19) % 4)) % 4;
      else              expQ = 0;
      checkAll($sformatf("held e%0d", n), (n >= 15) && (n <= 34), expQ);
    end
    I = 1'b0;

    // CE low for five cycles stretches the delay by five
    I = 1'b1; tick(); I = 1'b0;
    for (int n = 1; n <= 4; n++) tick();
    CE = 1'b0;
    for (int n = 5; n <= 9; n++) begin
      tick();
      checkAll($sformatf("stall e%0d", n), 1'b0, 1);
    end
    CE = 1'b1;
    for (int n = 10; n <= 21; n++) begin
      tick();
      checkAll($sformatf("stall e%0d", n), n == 20, (n <= 20) ? 1 : 0);
    end

    // synchronous load, with and without CE, and over a coincident pulse
    CE = 1'b0; L = 1'b1; D = 2'd2; tick();
    checkAll("load ce0", 1'b0, 2);
    CE = 1'b1; D = 2'd0; tick();
    checkAll("load zero", 1'b0, 0);
    D = 2'd2; tick();
    checkAll("load ce1", 1'b0, 2);
    D = 2'd1; I = 1'b1; tick();
    L = 1'b0; I = 1'b0;
    checkAll("load wins", 1'b0, 1);
    for (int n = 1; n <= 14; n++) tick();
    tick();
    checkAll("load drain e15", 1'b1, 1);
    tick();
    checkAll("load drain e16", 1'b0, 0);

    // asynchronous reset between edges while Q=2 with a pulse in flight
    CE = 1'b0; L = 1'b1; D = 2'd1; tick();
    L = 1'b0; CE = 1'b1; I = 1'b1; tick(); I = 1'b0;
    checkAll("pre-reset", 1'b0, 2);
    for (int n = 1; n <= 3; n++) tick();
    #2;
    RST_N = 1'b0;
    #1;
    checkValue("async rst Q", 32'(Q), 32'd0);
    checkValue("async rst OVR", 32'(OVR), 32'd0);
`ifdef SRL_RESET_EN
    checkValue("async rst O", 32'(O), 32'd0);
`endif
    #1;
    RST_N = 1'b1;
    for (int n = 4; n <= 20; n++) begin
      tick();
`ifdef SRL_RESET_EN
      checkAll($sformatf("post-rst e%0d", n), 1'b0, 0);
`else
      checkAll($sformatf("post-rst e%0d", n), n == 15, (n >= 16) ? 3 : 0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
